sync_fifo_core: RTL and testbench

Single-clock synchronous FIFO storing `depth` words of `width` bits in a register-file memory. Write and read are enabled by level-sensitive strobes. Full and empty flags are derived from an occupancy counter. The block is used as the generic buffering element between producer and consumer logic in the same clock domain.

---
 rtl/sync_fifo_core.sv | 77 +++++++
 tb/tb_sync_fifo_core.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with a register-file store, occupancy-counter flags and a
// registered read port (one-cycle read latency, no write-to-read bypass).
module sync_fifo_core #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [width-1:0] fifo_data_in,
  input  logic             fifo_write,
  input  logic             fifo_read,
  output logic [width-1:0] fifo_data_out,
  output logic             fifo_full,
  output logic             fifo_empty
);

  localparam int unsigned AddrW = $clog2(depth);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam logic [PtrW-1:0] DepthCnt = PtrW'(depth);

  logic [width-1:0] mem [depth];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  cnt_q, cnt_d;
  logic [width-1:0] data_out_q, data_out_d;
  logic             wr_en, rd_en;

  assign fifo_full     = (cnt_q == DepthCnt);
  assign fifo_empty    = (cnt_q == '0);
  assign fifo_data_out = data_out_q;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_en = fifo_read & ~fifo_empty;
  assign wr_en = fifo_write & (~fifo_full | rd_en) & rst_;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      data_out_d = mem[rd_ptr_q[AddrW-1:0]];
    end
    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + PtrW'(1);
      2'b01:   cnt_d = cnt_q - PtrW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AddrW-1:0]] <= fifo_data_in;
    end
  end

endmodule

// File: tb/tb_sync_fifo_core.sv
// Scoreboard bench for sync_fifo_core: stimulus pushes expected port values per
// edge, a negedge monitor pops and compares them.
module tb_sync_fifo_core;

  localparam int unsigned W = 16;
  localparam int unsigned D = 16;

  typedef struct packed {
    logic [W-1:0] dout;
    logic         empty;
    logic         full;
  } exp_t;

  logic         clk;
  logic         rst_;
  logic [W-1:0] din;
  logic         wr;
  logic         rd;
  logic [W-1:0] dout;
  logic         full;
  logic         empty;

  exp_t         sb[$];
  logic [W-1:0] model_q[$];
  logic [W-1:0] model_dout;
  int           total;
  int           bad;

  sync_fifo_core #(.width(W), .depth(D)) dut (
    .clk          (clk),
    .rst_         (rst_),
    .fifo_data_in (din),
    .fifo_write   (wr),
    .fifo_read    (rd),
    .fifo_data_out(dout),
    .fifo_full    (full),
    .fifo_empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are compared at the negedge following each driven edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_dout", 32'(dout), 32'(e.dout));
      check("sb_empty", 32'(empty), 32'(e.empty));
      check("sb_full", 32'(full), 32'(e.full));
    end
  end

  // One clock edge of stimulus; the queue model predicts the post-edge outputs.
  task automatic step(input logic rstv, input logic w, input logic r, input logic [W-1:0] d);
    bit rd_ok, wr_ok;
    @(negedge clk);
    rst_ = rstv;
    wr   = w;
    rd   = r;
    din  = d;
    @(posedge clk);
    if (!rstv) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      rd_ok = r && (model_q.size() > 0);
      wr_ok = w && ((model_q.size() < D) || rd_ok);
      if (rd_ok) model_dout = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
    end
    sb.push_back('{dout: model_dout, empty: (model_q.size() == 0),
                   full: (model_q.size() == D)});
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    model_dout = '0;
    rst_       = 1'b0;
    wr         = 1'b1;
    rd         = 1'b0;
    din        = 16'd7;

    // Write held during reset must be ignored.
    step(1'b0, 1'b1, 1'b0, 16'd7);
    #1 check("rst_dout", 32'(dout), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);

    step(1'b1, 1'b1, 1'b0, 16'd7);
    #1 check("first_write_empty", 32'(empty), 32'd0);

    step(1'b1, 1'b0, 1'b1, 16'd0);
    #1 check("round_trip", 32'(dout), 32'd7);
    check("round_trip_empty", 32'(empty), 32'd1);

    // Fill across the pointer wrap, then try to overfill.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 16'(i));
    #1 check("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'd103);
    #1 check("overfill_full", 32'(full), 32'd1);

    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b1, 16'd0);
    #1 check("drain_hold", 32'(dout), 32'd15);
    check("drain_empty", 32'(empty), 32'd1);

    // Concurrent read/write at occupancy 5.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 16'(100 + i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 16'(200 + i));
    #1 check("concur_dout", 32'(dout), 32'd103);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 16'd0);
    #1 check("concur_lag5", 32'(dout), 32'd203);

    // Both strobes on an empty FIFO: write only, no bypass.
    step(1'b1, 1'b1, 1'b1, 16'd55);
    #1 check("empty_both_dout", 32'(dout), 32'd203);
    check("empty_both_empty", 32'(empty), 32'd0);
    step(1'b1, 1'b0, 1'b1, 16'd0);
    #1 check("empty_both_read", 32'(dout), 32'd55);

    // Asynchronous reset between edges with three words queued.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'(i + 1));
    @(negedge clk);
    wr = 1'b0;
    @(posedge clk);
    #2 rst_ = 1'b0;
    #1 check("async_rst_dout", 32'(dout), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_full", 32'(full), 32'd0);
    model_q.delete();
    model_dout = '0;
    step(1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b1, 1'b0, 1'b1, 16'd0);
    #1 check("post_rst_read", 32'(dout), 32'd0);
    check("post_rst_empty", 32'(empty), 32'd1);

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
